// File: rtl/cp0_regfile_if.sv
// cp0_regfile_if
//   Decoder <-> CP0 bundle: mfc0 read port, mtc0 write port, M-stage
//   exception context (PC, delay-slot flag, exception code), hardware
//   interrupt lines, eret clear, and the CP0 responses (IntReq, EPCOut, DOut).
//   master : decoder / M-stage side (drives requests, receives responses)
//   slave  : cp0_regfile side
interface cp0_regfile_if #(
   parameter int HWINT_W = 6
);
   logic [4:0]         A1;         // mfc0 register number
   logic [4:0]         A2;         // mtc0 register number
   logic [31:0]        DIn;        // mtc0 write data
   logic               WE;         // mtc0 write enable (M stage)
   logic [31:0]        PCIn;       // macroscopic PC of M-stage instruction
   logic               BDIn;       // M-stage instruction sits in a delay slot
   logic [4:0]         ExcCodeIn;  // M-stage exception code, 0 = none
   logic [HWINT_W-1:0] HWInt;      // level-sensitive hardware interrupts
   logic               EXLClr;     // eret in M stage
   logic               IntReq;     // take exception/interrupt this cycle
   logic [31:0]        EPCOut;     // eret target
   logic [31:0]        DOut;       // mfc0 read data

   modport master (
      output A1, A2, DIn, WE, PCIn, BDIn, ExcCodeIn, HWInt, EXLClr,
      input  IntReq, EPCOut, DOut
   );

   modport slave (
      input  A1, A2, DIn, WE, PCIn, BDIn, ExcCodeIn, HWInt, EXLClr,
      output IntReq, EPCOut, DOut
   );
endinterface

// File: rtl/cp0_regfile.sv
// cp0_regfile
//   Coprocessor 0 for the P7 pipeline. Holds SR(12), Cause(13), EPC(14) and
//   the constant PRId(15); latches exception/interrupt context at the M stage
//   and raises IntReq combinationally in the same cycle.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-low reset
//   bus    - cp0_regfile_if.slave (A1/A2/DIn/WE/PCIn/BDIn/ExcCodeIn/HWInt/
//            EXLClr in; IntReq/EPCOut/DOut out)
// Build option:
//   CP0_EPC_BYPASS_EN - when defined, EPCOut forwards an in-flight mtc0 EPC
//                       write so an eret directly behind it sees the new value.
module cp0_regfile #(
   parameter logic [31:0] PRID    = 32'h2021_0701,
   parameter int          HWINT_W = 6
) (
   input  logic         clk,
   input  logic         reset,
   cp0_regfile_if.slave bus
);
   // Architectural state (only the implemented bits are stored)
   logic [HWINT_W-1:0] im_reg;
   logic               exl_reg;
   logic               ie_reg;
   logic               bd_reg;
   logic [HWINT_W-1:0] ip_reg;
   logic [4:0]         exc_code_reg;
   logic [29:0]        epc_reg;

   logic        int_p;
   logic        exc_p;
   logic        int_req;
   logic [29:0] epc_next;
   logic [4:0]  exc_code_next;
   logic [31:0] sr_word;
   logic [31:0] cause_word;
   logic [31:0] epc_word;
   logic        unused_pc_bits;

   // PC is word aligned; the low bits never reach EPC.
   assign unused_pc_bits = ^bus.PCIn[1:0];

   assign int_p   = (|(bus.HWInt & im_reg)) & ie_reg & ~exl_reg;
   assign exc_p   = (bus.ExcCodeIn != 5'd0) & ~exl_reg;
   assign int_req = int_p | exc_p;

   // A delay-slot instruction restarts at its branch, one word earlier.
   assign epc_next      = bus.BDIn ? (bus.PCIn[31:2] - 30'd1) : bus.PCIn[31:2];
   // Interrupts win over a simultaneous synchronous exception.
   assign exc_code_next = int_p ? 5'd0 : bus.ExcCodeIn;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im_reg       <= '0;
         exl_reg      <= 1'b0;
         ie_reg       <= 1'b0;
         bd_reg       <= 1'b0;
         ip_reg       <= '0;
         exc_code_reg <= 5'd0;
         epc_reg      <= 30'd0;
      end else begin
         // IP mirrors the interrupt lines every cycle, even inside a handler.
         ip_reg <= bus.HWInt;
         if (int_req) begin
            // The M-stage instruction is flushed, so any mtc0 is dropped.
            exl_reg      <= 1'b1;
            exc_code_reg <= exc_code_next;
            bd_reg       <= bus.BDIn;
            epc_reg      <= epc_next;
         end else if (bus.EXLClr) begin
            exl_reg <= 1'b0;
         end else if (bus.WE) begin
            case (bus.A2)
               5'd12: begin
                  im_reg  <= bus.DIn[10 +: HWINT_W];
                  exl_reg <= bus.DIn[1];
                  ie_reg  <= bus.DIn[0];
               end
               5'd14:   epc_reg <= bus.DIn[31:2];
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      sr_word                = 32'd0;
      sr_word[10 +: HWINT_W] = im_reg;
      sr_word[1]             = exl_reg;
      sr_word[0]             = ie_reg;

      cause_word                = 32'd0;
      cause_word[31]            = bd_reg;
      cause_word[10 +: HWINT_W] = ip_reg;
      cause_word[6:2]           = exc_code_reg;

      epc_word = {epc_reg, 2'b00};
   end

   always_comb begin
      bus.DOut = 32'd0;
      case (bus.A1)
         5'd12:   bus.DOut = sr_word;
         5'd13:   bus.DOut = cause_word;
         5'd14:   bus.DOut = epc_word;
         5'd15:   bus.DOut = PRID;
         default: bus.DOut = 32'd0;
      endcase
   end

`ifdef CP0_EPC_BYPASS_EN
   assign bus.EPCOut = (bus.WE && (bus.A2 == 5'd14) && !int_req)
                       ? {bus.DIn[31:2], 2'b00} : epc_word;
`else
   assign bus.EPCOut = epc_word;
`endif

   assign bus.IntReq = int_req;
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor 0 for the P7 pipeline.
- Responder end of the decoder's mfc0/mtc0/eret/IntReq interface.
- Holds SR, Cause, EPC and PRId, latches exception/interrupt state, and raises IntReq back to the decoder and NPC.
- Sits beside the M stage: macroscopic PC, exception code and branch-delay flag enter there, and mtc0 writes and eret clears take effect there.

Parameters:
- PRID, 32'h2021_0701, constant value returned for register 15.
- HWINT_W, 6, number of hardware interrupt lines (maps to IM/IP bits 15:10).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- A1  input  5  read register number (mfc0 rd).
- A2  input  5  write register number (mtc0 rd).
- DIn  input  32  mtc0 write data (forwarded rt).
- WE  input  1  mtc0 write enable from M stage.
- PCIn  input  32  PC of the M-stage instruction (macroscopic PC).
- BDIn  input  1  M-stage instruction is in a branch delay slot.
- ExcCodeIn  input  5  exception code of M-stage instruction; 0 = none.
- HWInt  input  6  hardware interrupt request lines, level-sensitive.
- EXLClr  input  1  eret in M stage.
- IntReq  output  1  take exception/interrupt this cycle (to decoder/NPC/flush).
- EPCOut  output  32  EPC value for eret target.
- DOut  output  32  combinational read data for A1.

Behaviour:
- Reset (reset=0, asynchronous): SR, Cause and EPC all 0. Consequences: IntReq=0, EPCOut=0, DOut=0 for A1=12/13/14.
- SR (12): bits 15:10 IM, bit 1 EXL, bit 0 IE are writable; all other bits read 0.
- Cause (13): bit 31 BD, bits 15:10 IP, bits 6:2 ExcCode; all other bits 0. Cause is read-only to mtc0.
- EPC (14): bits 31:2 stored, bits 1:0 always read 0.
- PRId (15): returns PRID. Writes are ignored.
- Any other A1 reads 0; any other A2 write is ignored.
- Interrupt pending: int_p = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- Exception pending: exc_p = (ExcCodeIn != 0) & ~SR.EXL.
- IntReq = int_p | exc_p, combinational, same cycle.
- Cause.IP <= HWInt on every clock edge, unconditionally, including while EXL=1.
- On a clock edge with IntReq=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_p ? 0 : ExcCodeIn (interrupt has priority over exception).
  - Cause.BD <= BDIn.
  - EPC <= BDIn ? {PCIn[31:2],2'b00} - 4 : {PCIn[31:2],2'b00}.
- Priority per edge: IntReq > EXLClr > WE.
  - With IntReq=1, the mtc0 write is dropped (the instruction is flushed).
  - With EXLClr=1 and IntReq=0: SR.EXL <= 0 and nothing else changes. A simultaneous WE is also dropped, because eret and mtc0 cannot share M.
  - With WE=1 only: the addressed register is written at the edge. For SR, a written EXL bit is taken as written.
- Once EXL=1, IntReq stays 0 until EXLClr; no nested exceptions.
- Read-during-write:
  - DOut shows the old value for the rest of the write cycle and the new value from the next cycle.
  - EPCOut likewise, except as stated under Optional Feature.
- IntReq depends only on current registers and inputs; there is no latency beyond the combinational path.

Optional Feature:
- Macro CP0_EPC_BYPASS_EN.
- Defined: EPCOut = (WE && A2==14 && !IntReq) ? {DIn[31:2],2'b00} : EPC. This lets an eret immediately behind an mtc0 EPC read the fresh value; it matches the decoder's mtepc hint.
- Undefined: EPCOut = EPC register only. The pipeline must stall eret behind mtc0 EPC.

Test Plan:
- Reset released; SR=0x0000_0401 (mtc0 A2=12), HWInt=6'b000001 -> IntReq=1 that cycle. Next cycle: SR.EXL=1, Cause.ExcCode=0, EPC=PCIn, IntReq=0.
- ExcCodeIn=5'd4, PCIn=0x0000_3008, BDIn=1, EXL=0 -> IntReq=1. After the edge: Cause=0x8000_0010, EPC=0x0000_3004.
- HWInt asserted together with ExcCodeIn=10 and IM/IE enabled -> ExcCode latched 0 (interrupt wins).
- EXL=1, ExcCodeIn=12 -> IntReq=0 and registers unchanged. Then EXLClr=1 -> EXL=0, and IntReq goes to 1 if ExcCodeIn is still nonzero.
- mtc0 EPC with DIn=0x0000_3103 in the same cycle as IntReq=1 -> EPC takes the exception PC, not 0x3100.
- With CP0_EPC_BYPASS_EN: WE=1, A2=14, DIn=0x0000_4000 -> EPCOut=0x0000_4000 in the same cycle. Without the macro, EPCOut shows the old value until the next cycle. A1=15 reads PRID; a write to A2=15 has no effect.
